// File: rtl/dma_write_feeder.sv
// Write-side DMA sequencer: buffers source words and issues 4 KB-safe AXI INCR bursts
// of up to 16 beats to the write master, streaming FIFO data one word per accepted beat.
module dma_write_feeder #(
  parameter int unsigned DEPTH = 32,
  parameter logic [3:0]  WR_ID = 4'd0
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        start,
  input  logic [31:0] dst_addr,
  input  logic [15:0] total_words,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] A,
  output logic [3:0]  burst_LEN,
  output logic [3:0]  id_in,
  output logic [3:0]  bweb_in,
  output logic        write_signal,
  output logic [31:0] DI,
  input  logic        wr_beat_ack,
  input  logic        wr_burst_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StPlan, StIssue, StData, StFin} state_e;

  state_e state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, push, pop;

  logic [31:0] cur_addr_q;
  logic [15:0] remaining_q;
  logic [31:0] a_q;
  logic [3:0]  len_q;
  logic [4:0]  beat_cnt_q;

  logic [12:0] to_bnd_bytes;
  logic [10:0] to_bnd;
  logic [15:0] beats_lim;
  logic [4:0]  beats;
  logic        plan_go;
  logic [15:0] burst_words;
  logic [31:0] addr_inc;

  // FIFO
  assign full     = (count_q == FullCount);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Acks beyond the last beat of the burst must not consume data.
  assign pop      = (state_q == StData) && wr_beat_ack && (beat_cnt_q <= {1'b0, len_q}) &&
                    (count_q != '0);

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign DI = (count_q == '0) ? 32'h0 : mem[rd_ptr_q];

  // Burst planning: limited by 16 beats, words left and distance to the next 4 KB page.
  assign to_bnd_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
  assign to_bnd       = 11'(to_bnd_bytes >> 2);

  always_comb begin
    beats_lim = 16'd16;
    if (remaining_q < beats_lim) beats_lim = remaining_q;
    if ({5'd0, to_bnd} < beats_lim) beats_lim = {5'd0, to_bnd};
    beats = 5'(beats_lim);
  end

  assign plan_go     = 32'(count_q) >= 32'(beats);
  assign burst_words = {12'd0, len_q} + 16'd1;
  assign addr_inc    = {14'd0, burst_words, 2'b00};

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESETn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (total_words == 16'd0) ? StFin : StPlan;
      StPlan:  if (plan_go) state_d = StIssue;
      StIssue: state_d = StData;
      StData:  if (wr_burst_done) state_d = (remaining_q == burst_words) ? StFin : StPlan;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy         = (state_q != StIdle);
    done         = (state_q == StFin);
    write_signal = (state_q == StIssue);
  end

  // Transfer datapath
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      a_q         <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_addr_q  <= dst_addr;
            remaining_q <= total_words;
          end
        end
        StPlan: begin
          if (plan_go) begin
            a_q        <= cur_addr_q;
            len_q      <= 4'(beats - 5'd1);
            beat_cnt_q <= '0;
          end
        end
        StData: begin
          if (pop) beat_cnt_q <= beat_cnt_q + 5'd1;
          if (wr_burst_done) begin
            cur_addr_q  <= cur_addr_q + addr_inc;
            remaining_q <= remaining_q - burst_words;
          end
        end
        default: ;
      endcase
    end
  end

  assign A         = a_q;
  assign burst_LEN = len_q;
  assign id_in     = WR_ID;
  assign bweb_in   = 4'hF;

endmodule

// File: tb/tb_dma_write_feeder.sv
// Randomized self-checking bench for dma_write_feeder: a queue models the FIFO and the
// burst split is recomputed arithmetically from the start address and word count.
module tb_dma_write_feeder;

  localparam int unsigned DEPTH = 32;
  localparam logic [3:0]  WR_ID = 4'd5;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] total_words = '0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] A;
  logic [3:0]  burst_LEN, id_in, bweb_in;
  logic        write_signal;
  logic [31:0] DI;
  logic        wr_beat_ack = 1'b0;
  logic        wr_burst_done = 1'b0;

  dma_write_feeder #(.DEPTH(DEPTH), .WR_ID(WR_ID)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .dst_addr(dst_addr),
    .total_words(total_words), .busy(busy), .done(done), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .A(A), .burst_LEN(burst_LEN), .id_in(id_in),
    .bweb_in(bweb_in), .write_signal(write_signal), .DI(DI), .wr_beat_ack(wr_beat_ack),
    .wr_burst_done(wr_burst_done)
  );

  always #5 ACLK = ~ACLK;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mq[$];
  int          beats_left = 0;
  int          feed_mode = 0;
  int          feed_ctr = 0;
  logic [31:0] word_ctr = 32'h1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] head_exp();
    return (mq.size() > 0) ? mq[0] : 32'h0;
  endfunction

  // One clock: called just after a falling edge, returns at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic ack, input logic bd);
    check_eq("in_ready", in_ready, 32'(mq.size() < DEPTH));
    in_valid = v; in_data = d; wr_beat_ack = ack; wr_burst_done = bd;
    if (v && mq.size() < DEPTH) mq.push_back(d);
    if (ack && beats_left > 0 && mq.size() > 0) begin
      void'(mq.pop_front());
      beats_left--;
    end
    @(negedge ACLK);
    in_valid = 1'b0; wr_beat_ack = 1'b0; wr_burst_done = 1'b0;
  endtask

  task automatic tick(input logic ack, input logic bd);
    logic v;
    v = 1'b0;
    case (feed_mode)
      1: v = ($urandom_range(0, 1) == 1);
      2: begin v = (feed_ctr % 3 == 0); feed_ctr++; end
      default: v = 1'b0;
    endcase
    cycle(v, word_ctr, ack, bd);
    word_ctr++;
  endtask

  task automatic do_reset(input int n);
    ARESETn = 1'b1; start = 1'b0;
    in_valid = 1'b0; wr_beat_ack = 1'b0; wr_burst_done = 1'b0;
    repeat (n) @(negedge ACLK);
    mq.delete(); beats_left = 0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ws", write_signal, 0);
    check_eq("rst_A", A, 0);
    check_eq("rst_len", burst_LEN, 0);
    check_eq("rst_id", id_in, WR_ID);
    check_eq("rst_bweb", bweb_in, 4'hF);
    check_eq("rst_DI", DI, 0);
    check_eq("rst_in_ready", in_ready, 1);
    ARESETn = 1'b0;
  endtask

  task automatic preload(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) cycle(1'b1, base + 32'(i), 1'b0, 1'b0);
  endtask

  task automatic run_transfer(input logic [31:0] addr, input int n);
    logic [31:0] ea[$];
    int          eb[$];
    logic [31:0] a;
    int          rem, bnd, b;
    bit          prev, seen, bad;
    a = addr; rem = n;
    while (rem > 0) begin
      bnd = (4096 - int'(a[11:0])) / 4;
      b = 16;
      if (rem < b) b = rem;
      if (bnd < b) b = bnd;
      ea.push_back(a); eb.push_back(b);
      a = a + 32'(4 * b);
      rem -= b;
    end
    start = 1'b1; dst_addr = addr; total_words = 16'(n);
    tick(1'b0, 1'b0);
    start = 1'b0;
    if (n == 0) begin
      check_eq("zl_busy", busy, 1);
      check_eq("zl_done", done, 1);
      check_eq("zl_ws", write_signal, 0);
      tick(1'b0, 1'b0);
      check_eq("zl_busy_end", busy, 0);
      check_eq("zl_done_end", done, 0);
      check_eq("zl_ws_end", write_signal, 0);
      return;
    end
    for (int bi = 0; bi < ea.size(); bi++) begin
      // Launch is due the cycle after PLAN sees enough buffered words.
      prev = 1'b0; seen = 1'b0; bad = 1'b0;
      for (int t = 0; t < 400 && !seen; t++) begin
        if (!bad) begin
          check_eq("ws_timing", write_signal, 32'(prev));
          if (write_signal !== prev) bad = 1'b1;
        end
        if (write_signal === 1'b1) seen = 1'b1;
        else begin
          prev = (mq.size() >= eb[bi]);
          tick(1'b0, 1'b0);
        end
      end
      if (!seen) begin
        check_eq("ws_timeout", write_signal, 1);
        do_reset(1);
        return;
      end
      check_eq("burst_A", A, ea[bi]);
      check_eq("burst_len", burst_LEN, 32'(eb[bi] - 1));
      check_eq("burst_id", id_in, WR_ID);
      check_eq("burst_bweb", bweb_in, 4'hF);
      check_eq("burst_busy", busy, 1);
      check_eq("burst_done", done, 0);
      beats_left = eb[bi];
      tick(1'b0, 1'b0);
      check_eq("ws_pulse", write_signal, 0);
      for (int k = 0; k < eb[bi]; k++) begin
        repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0);
        check_eq("DI_beat", DI, head_exp());
        tick(1'b1, 1'b0);
      end
      if ($urandom_range(0, 1) == 1) begin
        tick(1'b1, 1'b0);
        check_eq("DI_spurious", DI, head_exp());
      end
      check_eq("hold_A", A, ea[bi]);
      check_eq("hold_len", burst_LEN, 32'(eb[bi] - 1));
      check_eq("data_done", done, 0);
      tick(1'b0, 1'b1);
    end
    check_eq("fin_done", done, 1);
    check_eq("fin_busy", busy, 1);
    tick(1'b0, 1'b0);
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          n;
    bit          seen;
    @(negedge ACLK);
    do_reset(2);

    // Multi-burst, preloaded 0x100..0x113
    preload(20, 32'h100);
    run_transfer(32'h0001_0000, 20);

    // 4 KB split
    do_reset(1);
    preload(5, 32'h200);
    run_transfer(32'h0000_0FF8, 5);

    // Starvation: one word every 3 cycles
    do_reset(1);
    feed_mode = 2; feed_ctr = 1;
    run_transfer(32'h0000_4000, 8);
    feed_mode = 0;

    // Zero length
    do_reset(1);
    run_transfer(32'h0000_5000, 0);

    // Full FIFO, extra word rejected, then drain exactly DEPTH words
    do_reset(1);
    preload(DEPTH, 32'h300);
    check_eq("full_in_ready", in_ready, 0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_transfer(32'h0000_2000, DEPTH);
    check_eq("drained_DI", DI, 0);
    check_eq("drained_in_ready", in_ready, 1);

    // Reset in the middle of a burst
    do_reset(1);
    preload(16, 32'h400);
    start = 1'b1; dst_addr = 32'h3000; total_words = 16'd16;
    cycle(1'b0, 0, 1'b0, 1'b0);
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (write_signal === 1'b1) seen = 1'b1;
      else cycle(1'b0, 0, 1'b0, 1'b0);
    end
    check_eq("mid_ws_seen", write_signal, 1);
    beats_left = 16;
    cycle(1'b0, 0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);
    do_reset(1);
    for (int t = 0; t < 4; t++) begin
      check_eq("post_rst_done", done, 0);
      check_eq("post_rst_busy", busy, 0);
      cycle(1'b0, 0, 1'b0, 1'b0);
    end

    // Randomized transfers
    for (int it = 0; it < 12; it++) begin
      do_reset(1);
      preload($urandom_range(0, DEPTH), $urandom);
      if ($urandom_range(0, 1) == 1)
        addr = {$urandom_range(0, 32'hFFFFF) << 12} | 32'(4096 - 4 * $urandom_range(1, 40));
      else
        addr = $urandom & 32'hFFFF_FFFC;
      if (it == 0) addr = 32'hFFFF_FFF8;
      n = $urandom_range(0, 60);
      feed_mode = 1;
      run_transfer(addr, n);
      feed_mode = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_write_feeder.md
# dma_write_feeder

Write-side sequencer of the DMA engine, upstream of the AXI write master. It buffers source words from the DMA read path in an internal FIFO and splits one transfer of `total_words` into AXI INCR bursts of at most 16 beats, none of which crosses a 4 KB boundary. For each burst it drives the write master's request sideband: address, length, ID, strobes and a one-cycle `write_signal` pulse. It then presents FIFO data on `DI` and pops one word per accepted beat.

## Interface
- `DEPTH`, default 32: FIFO depth in 32-bit words. Must be a power of 2 and at least 16.
- `WR_ID`, default 4'd0: value driven on `id_in` for every burst.
- `ACLK`, in, 1: clock. All logic is on the rising edge.
- `ARESETn`, in, 1: reset. Synchronous and active-high despite the name: 1 = reset.
- `start`, in, 1: starts a transfer. Sampled only in IDLE.
- `dst_addr`, in, 32: destination byte address, word-aligned. Sampled with `start`.
- `total_words`, in, 16: number of words to write. Sampled with `start`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the transfer completes.
- `in_valid`, in, 1: source word valid.
- `in_data`, in, 32: source word.
- `in_ready`, out, 1: equals !full.
- `A`, out, 32: burst start address.
- `burst_LEN`, out, 4: beats - 1.
- `id_in`, out, 4: burst ID.
- `bweb_in`, out, 4: write strobes, constant 4'hF.
- `write_signal`, out, 1: burst request pulse.
- `DI`, out, 32: FIFO head word.
- `wr_beat_ack`, in, 1: the write master completed one W handshake this cycle.
- `wr_burst_done`, in, 1: the write master completed the B handshake this cycle.

## Operation
- **States:** IDLE, PLAN, ISSUE, DATA, FIN.
- **IDLE:**
  - On `start`, latch `cur_addr` = `dst_addr` and `remaining` = `total_words`.
  - Next state is FIN if `total_words` == 0, otherwise PLAN.
  - `start` is ignored in every other state.
- **PLAN:**
  - `to_bnd` = (4096 - `cur_addr[11:0]`) >> 2, 11 bits, range 1..1024.
  - `beats` = min(16, `remaining`, `to_bnd`), 5 bits, range 1..16.
  - When FIFO `count` >= `beats`: register `A` = `cur_addr`, `burst_LEN` = `beats` - 1 and `beat_cnt` = 0, then go to ISSUE. Otherwise stay in PLAN.
  - Bursts are launched only when fully buffered, because the write master holds WVALID high for the whole burst.
- **ISSUE:** `write_signal` = 1 for exactly this cycle; next state is DATA.
- **DATA:**
  - Each `wr_beat_ack` with `beat_cnt` <= `burst_LEN` pops the FIFO and increments `beat_cnt`.
  - A `wr_beat_ack` after the last beat is ignored: no pop.
  - On `wr_burst_done`: `cur_addr` += (`burst_LEN`+1)*4, mod 2^32, and `remaining` -= `burst_LEN`+1. Next state is FIN if the new `remaining` == 0, otherwise PLAN.
- **FIN:** `done` = 1 for one cycle, then IDLE.
- **Stable outputs:** `A`, `burst_LEN` and `id_in` hold from ISSUE through the end of DATA.
- **FIFO:**
  - Push occurs when `in_valid` && `in_ready`. Pushing is allowed in any state, including IDLE (preload).
  - On a simultaneous push and pop when full: `in_ready` is 0, so the push is not accepted.
  - On a simultaneous push and pop when not full: `count` is unchanged.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
- **DI:** FIFO head word, combinational. Meaningful only in DATA.

## Timing
- **Reset (synchronous, any state):** next edge forces IDLE, FIFO empty, `count` = 0.
  - Outputs after reset: `in_ready`=1, `busy`=0, `done`=0, `write_signal`=0, `A`=0, `burst_LEN`=0, `id_in`=`WR_ID`, `bweb_in`=4'hF, `DI`=0.
  - Reset mid-burst abandons the transfer; no `done`.
- **Start latency:** `start` at cycle 0 with data buffered → PLAN at cycle 1 → `write_signal` at cycle 2.
- **Burst-to-burst latency:** `wr_burst_done` at cycle n → PLAN at n+1 → next `write_signal` at n+2 at the earliest.
- **FIFO visibility:** a word pushed at cycle k is in `count` and visible on `DI` at k+1.
- **Beat consumption:** a beat popped at cycle k exposes the next word on `DI` at k+1.
- **Zero length:** `total_words` = 0 → `done` one cycle after `start`; `write_signal` is never asserted.
- **Done latency:** `done` is asserted the cycle after the final `wr_burst_done`.

## Test plan
- **Reset:** assert `ARESETn`=1 for 2 cycles → all outputs at their reset values, `in_ready`=1, `count`=0. Repeat the reset during DATA → IDLE on the next cycle and FIFO empty.
- **Multi-burst:**
  - Stimulus: preload 20 words 0x100..0x113, then `start` with `dst_addr`=0x0001_0000, `total_words`=20.
  - Required bursts: (A=0x0001_0000, LEN=15), then (A=0x0001_0040, LEN=3).
  - Required `DI` sequence: 0x100..0x113 in order.
  - `done` pulses once.
- **4 KB split:**
  - Stimulus: `dst_addr`=0x0000_0FF8, `total_words`=5, data preloaded.
  - Required bursts: (A=0xFF8, LEN=1), then (A=0x1000, LEN=2).
- **Starvation:**
  - Stimulus: `start` 8 words with FIFO empty, then push one word every 3 cycles.
  - Required: `write_signal` stays 0 until `count`=8, then pulses 2 cycles after the 8th push.
- **Zero length:** `total_words`=0 → `busy` is high for 1 cycle, `done` at cycle 1, no `write_signal`.
- **Full FIFO:**
  - Stimulus: push `DEPTH` words with no transfer running.
  - Required: `in_ready`=0 after the `DEPTH`th push, and an extra `in_valid` leaves `count`=`DEPTH`.
  - Further: a spurious `wr_beat_ack` after the last beat of a burst causes no pop.
